// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter onto one shared memory port.
// A request is read|write; the winning port's request is registered at grant and
// the shared pmem_* bus is driven only from those registers until pmem_resp.
// Optional feature: define ARB_RR_EN to alternate between ports when both request
// in IDLE. Without it, the data port always wins a simultaneous request.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] inst_mem_address,
   input  logic        inst_mem_read,
   input  logic        inst_mem_write,
   input  logic [3:0]  inst_mem_byte_enable,
   input  logic [31:0] inst_mem_wdata,
   output logic [31:0] inst_mem_rdata,
   output logic        inst_mem_resp,

   input  logic [31:0] data_mem_address,
   input  logic        data_mem_read,
   input  logic        data_mem_write,
   input  logic [3:0]  data_mem_byte_enable,
   input  logic [31:0] data_mem_wdata,
   output logic [31:0] data_mem_rdata,
   output logic        data_mem_resp,

   output logic [31:0] pmem_address,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [3:0]  pmem_byte_enable,
   output logic [31:0] pmem_wdata,
   input  logic [31:0] pmem_rdata,
   input  logic        pmem_resp
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] INST = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0]  state_q, state_d;

   logic        inst_req, data_req;
   logic        grant_inst, grant_data;
   logic        busy_done;

   logic [31:0] sel_address;
   logic        sel_read;
   logic        sel_write;
   logic [3:0]  sel_byte_enable;
   logic [31:0] sel_wdata;

   logic [31:0] addr_q;
   logic        read_q;
   logic        write_q;
   logic [3:0]  be_q;
   logic [31:0] wdata_q;

   assign inst_req  = inst_mem_read | inst_mem_write;
   assign data_req  = data_mem_read | data_mem_write;

   // A transaction completes on pmem_resp only while a port owns the bus;
   // pmem_resp seen in IDLE is stale and has no effect.
   assign busy_done = (state_q != IDLE) & pmem_resp;

`ifdef ARB_RR_EN
   // 1: data port is served next on a tie, 0: instruction port is served next.
   logic data_next_q;

   // Remember which port was served last so the other one wins the next tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_next_q <= 1'b1;
      end else if (grant_data) begin
         data_next_q <= 1'b0;
      end else if (grant_inst) begin
         data_next_q <= 1'b1;
      end
   end
`endif

   // Grant decision: only in IDLE, single requester wins outright, ties resolved
   // by fixed data priority or by the round-robin pointer.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (state_q == IDLE) begin
         if (data_req && inst_req) begin
`ifdef ARB_RR_EN
            if (data_next_q) begin
               grant_data = 1'b1;
            end else begin
               grant_inst = 1'b1;
            end
`else
            grant_data = 1'b1;
`endif
         end else if (data_req) begin
            grant_data = 1'b1;
         end else if (inst_req) begin
            grant_inst = 1'b1;
         end
      end
   end

   // Next-state logic; a completing cycle always returns to IDLE, so no new
   // grant can be made in the same cycle as an accepted pmem_resp.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d = DATA;
            end else if (grant_inst) begin
               state_d = INST;
            end
         end
         INST, DATA: begin
            if (pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Select the winning port's request; read+write together becomes a write only.
   always_comb begin
      sel_address     = inst_mem_address;
      sel_read        = inst_mem_read & ~inst_mem_write;
      sel_write       = inst_mem_write;
      sel_byte_enable = inst_mem_byte_enable;
      sel_wdata       = inst_mem_wdata;
      if (grant_data) begin
         sel_address     = data_mem_address;
         sel_read        = data_mem_read & ~data_mem_write;
         sel_write       = data_mem_write;
         sel_byte_enable = data_mem_byte_enable;
         sel_wdata       = data_mem_wdata;
      end
   end

   // Capture the request at grant; drop read/write when the memory completes.
   // Address/data fields are left holding the last transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_q  <= 32'h0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
      end else if (grant_inst || grant_data) begin
         addr_q  <= sel_address;
         read_q  <= sel_read;
         write_q <= sel_write;
         be_q    <= sel_byte_enable;
         wdata_q <= sel_wdata;
      end else if (busy_done) begin
         read_q  <= 1'b0;
         write_q <= 1'b0;
      end
   end

   // Shared memory bus comes straight from the capture registers.
   always_comb begin
      pmem_address     = addr_q;
      pmem_read        = read_q;
      pmem_write       = write_q;
      pmem_byte_enable = be_q;
      pmem_wdata       = wdata_q;
   end

   // Completion is routed combinationally to the owning port only; rdata is
   // forced to zero whenever the port's resp is low.
   always_comb begin
      inst_mem_resp  = (state_q == INST) & pmem_resp;
      data_mem_resp  = (state_q == DATA) & pmem_resp;
      inst_mem_rdata = inst_mem_resp ? pmem_rdata : 32'h0;
      data_mem_rdata = data_mem_resp ? pmem_rdata : 32'h0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

`ifdef ARB_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic [31:0] inst_mem_address, inst_mem_wdata, inst_mem_rdata;
   logic        inst_mem_read, inst_mem_write, inst_mem_resp;
   logic [3:0]  inst_mem_byte_enable;
   logic [31:0] data_mem_address, data_mem_wdata, data_mem_rdata;
   logic        data_mem_read, data_mem_write, data_mem_resp;
   logic [3:0]  data_mem_byte_enable;
   logic [31:0] pmem_address, pmem_wdata, pmem_rdata;
   logic        pmem_read, pmem_write, pmem_resp;
   logic [3:0]  pmem_byte_enable;

   int n_checks = 0;
   int n_fail   = 0;

   mem_arbiter dut (
      .clk                  (clk),
      .rst                  (rst),
      .inst_mem_address     (inst_mem_address),
      .inst_mem_read        (inst_mem_read),
      .inst_mem_write       (inst_mem_write),
      .inst_mem_byte_enable (inst_mem_byte_enable),
      .inst_mem_wdata       (inst_mem_wdata),
      .inst_mem_rdata       (inst_mem_rdata),
      .inst_mem_resp        (inst_mem_resp),
      .data_mem_address     (data_mem_address),
      .data_mem_read        (data_mem_read),
      .data_mem_write       (data_mem_write),
      .data_mem_byte_enable (data_mem_byte_enable),
      .data_mem_wdata       (data_mem_wdata),
      .data_mem_rdata       (data_mem_rdata),
      .data_mem_resp        (data_mem_resp),
      .pmem_address         (pmem_address),
      .pmem_read            (pmem_read),
      .pmem_write           (pmem_write),
      .pmem_byte_enable     (pmem_byte_enable),
      .pmem_wdata           (pmem_wdata),
      .pmem_rdata           (pmem_rdata),
      .pmem_resp            (pmem_resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      inst_mem_address = 32'h0; inst_mem_read = 1'b0; inst_mem_write = 1'b0;
      inst_mem_byte_enable = 4'h0; inst_mem_wdata = 32'h0;
      data_mem_address = 32'h0; data_mem_read = 1'b0; data_mem_write = 1'b0;
      data_mem_byte_enable = 4'h0; data_mem_wdata = 32'h0;
      pmem_rdata = 32'h0; pmem_resp = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   // Outputs must all be zero while reset is held, whatever the inputs do.
   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      inst_mem_read = 1'b1; inst_mem_address = 32'h44;
      data_mem_write = 1'b1; data_mem_address = 32'h88; data_mem_wdata = 32'h1234_5678;
      data_mem_byte_enable = 4'hF;
      pmem_resp = 1'b1; pmem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      n_checks++;
      if ({pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata} !== 70'h0) begin
         n_fail++;
         $display("FAIL reset_pmem: got addr=%h rd=%b wr=%b be=%h wd=%h, want all 0",
                  pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata);
      end
      n_checks++;
      if ({inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata} !== 66'h0) begin
         n_fail++;
         $display("FAIL reset_ports: got iresp=%b dresp=%b ird=%h drd=%h, want all 0",
                  inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({pmem_read, pmem_write} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_release_idle: got rd=%b wr=%b, want 0 0", pmem_read, pmem_write);
      end
   endtask

   // Single instruction read, memory answers two cycles after pmem_read rises.
   task automatic test_inst_read();
      int iresp_cnt = 0, dresp_cnt = 0, resp_cycle = -1;
      logic [31:0] got = 32'h0;
      do_reset();
      @(posedge clk); #1;
      inst_mem_address = 32'h0000_0060; inst_mem_read = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 4) inst_mem_read = 1'b0;
         pmem_resp  = (c == 3);
         pmem_rdata = (c == 3) ? 32'h0000_0013 : 32'hA5A5_A5A5;
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (pmem_read !== 1'b0) begin
               n_fail++;
               $display("FAIL inst_read_grant_latency: pmem_read=%b in request cycle, want 0",
                        pmem_read);
            end
         end
         if (c == 1) begin
            n_checks++;
            if ({pmem_read, pmem_write, pmem_address} !== {1'b1, 1'b0, 32'h60}) begin
               n_fail++;
               $display("FAIL inst_read_pmem: got rd=%b wr=%b addr=%h, want 1 0 00000060",
                        pmem_read, pmem_write, pmem_address);
            end
         end
         if (c == 2) begin
            n_checks++;
            if (inst_mem_rdata !== 32'h0) begin
               n_fail++;
               $display("FAIL inst_rdata_gated: got %h while resp=0, want 0", inst_mem_rdata);
            end
         end
         if (inst_mem_resp) begin
            iresp_cnt++; resp_cycle = c; got = inst_mem_rdata;
         end
         if (data_mem_resp) dresp_cnt++;
      end
      n_checks++;
      if ({iresp_cnt, resp_cycle, got} !== {32'd1, 32'd3, 32'h13}) begin
         n_fail++;
         $display("FAIL inst_read_resp: got count=%0d cycle=%0d rdata=%h, want 1 3 00000013",
                  iresp_cnt, resp_cycle, got);
      end
      n_checks++;
      if (dresp_cnt !== 0) begin
         n_fail++;
         $display("FAIL inst_read_no_data_resp: got %0d data resps, want 0", dresp_cnt);
      end
   endtask

   // Single data write with partial byte enables.
   task automatic test_data_write();
      int dresp_cnt = 0, iresp_cnt = 0, rd_seen = 0;
      do_reset();
      @(posedge clk); #1;
      data_mem_address = 32'h100; data_mem_write = 1'b1;
      data_mem_wdata = 32'hDEAD_BEEF; data_mem_byte_enable = 4'b0011;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 3) data_mem_write = 1'b0;
         pmem_resp = (c == 2);
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if ({pmem_write, pmem_address, pmem_wdata, pmem_byte_enable} !==
                {1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
               n_fail++;
               $display("FAIL data_write_pmem: got wr=%b addr=%h wd=%h be=%b, want 1 100 deadbeef 0011",
                        pmem_write, pmem_address, pmem_wdata, pmem_byte_enable);
            end
         end
         if (pmem_read) rd_seen++;
         if (data_mem_resp) dresp_cnt++;
         if (inst_mem_resp) iresp_cnt++;
      end
      n_checks++;
      if ({dresp_cnt, iresp_cnt, rd_seen} !== {32'd1, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL data_write_resp: got dresp=%0d iresp=%0d rd_cycles=%0d, want 1 0 0",
                  dresp_cnt, iresp_cnt, rd_seen);
      end
   endtask

   // Both ports request continuously; record who is served in the first three rounds.
   task automatic test_back_to_back();
      int order[3] = '{-1, -1, -1};
      int exp_order[3];
      int n = 0;
      logic bump = 1'b0;
      exp_order = RrEn ? '{2, 1, 2} : '{2, 2, 2};
      do_reset();
      @(posedge clk); #1;
      inst_mem_address = 32'h400; inst_mem_read = 1'b1;
      data_mem_address = 32'h800; data_mem_read = 1'b1;
      for (int c = 0; c < 40 && n < 3; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (bump) data_mem_address = data_mem_address + 32'h4;
         bump = 1'b0;
         pmem_resp  = pmem_read | pmem_write;
         pmem_rdata = $urandom;
         @(negedge clk);
         if (inst_mem_resp || data_mem_resp) begin
            order[n] = data_mem_resp ? 2 : 1;
            n_checks++;
            if (pmem_address !== (data_mem_resp ? data_mem_address : 32'h400)) begin
               n_fail++;
               $display("FAIL b2b_addr round %0d: got %h, want %h", n, pmem_address,
                        data_mem_resp ? data_mem_address : 32'h400);
            end
            if (data_mem_resp) bump = 1'b1;
            n++;
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (order[k] !== exp_order[k]) begin
            n_fail++;
            $display("FAIL b2b_order round %0d: got port %0d, want port %0d (1=inst 2=data)",
                     k, order[k], exp_order[k]);
         end
      end
   endtask

   // Reset in the middle of a data read, then a stale pmem_resp afterwards.
   task automatic test_reset_mid();
      do_reset();
      @(posedge clk); #1;
      data_mem_address = 32'h300; data_mem_read = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({pmem_read, pmem_address} !== {1'b1, 32'h300}) begin
         n_fail++;
         $display("FAIL reset_mid_started: got rd=%b addr=%h, want 1 00000300",
                  pmem_read, pmem_address);
      end
      @(posedge clk); #1;
      rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'h1234_5678;
      @(negedge clk);
      n_checks++;
      if ({pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
           inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata} !== 136'h0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got rd=%b addr=%h dresp=%b drd=%h, want all 0",
                  pmem_read, pmem_address, data_mem_resp, data_mem_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b1; data_mem_read = 1'b0; pmem_resp = 1'b1; pmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      n_checks++;
      if ({inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata,
           pmem_read, pmem_write} !== 68'h0) begin
         n_fail++;
         $display("FAIL reset_mid_stale_resp: got iresp=%b dresp=%b rd=%b wr=%b, want 0",
                  inst_mem_resp, data_mem_resp, pmem_read, pmem_write);
      end
      // A fresh request must be served normally, proving the FSM sits in IDLE.
      @(posedge clk); #1;
      pmem_resp = 1'b0; data_mem_address = 32'h304; data_mem_read = 1'b1;
      @(posedge clk); #1;
      pmem_resp = 1'b1; pmem_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      n_checks++;
      if ({pmem_read, pmem_address, data_mem_resp, data_mem_rdata} !==
          {1'b1, 32'h304, 1'b1, 32'h0BAD_F00D}) begin
         n_fail++;
         $display("FAIL reset_mid_recover: got rd=%b addr=%h dresp=%b drd=%h, want 1 304 1 0badf00d",
                  pmem_read, pmem_address, data_mem_resp, data_mem_rdata);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   // Instruction address changes while owned; captured address must hold.
   task automatic test_addr_hold();
      do_reset();
      @(posedge clk); #1;
      inst_mem_address = 32'h500; inst_mem_read = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         if (c == 1) inst_mem_address = 32'h0000_9999;
         if (c == 5) inst_mem_read = 1'b0;
         pmem_resp = (c == 4);
         @(negedge clk);
         if (c <= 4) begin
            n_checks++;
            if (pmem_address !== 32'h500) begin
               n_fail++;
               $display("FAIL addr_hold cycle %0d: got %h, want 00000500", c, pmem_address);
            end
         end
      end
   endtask

   // Read and write asserted together must become a single write.
   task automatic test_rw_both();
      int dresp_cnt = 0;
      do_reset();
      @(posedge clk); #1;
      data_mem_address = 32'h200; data_mem_read = 1'b1; data_mem_write = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 2) begin data_mem_read = 1'b0; data_mem_write = 1'b0; end
         pmem_resp = (c == 1);
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if ({pmem_write, pmem_read, pmem_address} !== {1'b1, 1'b0, 32'h200}) begin
               n_fail++;
               $display("FAIL rw_both_pmem: got wr=%b rd=%b addr=%h, want 1 0 00000200",
                        pmem_write, pmem_read, pmem_address);
            end
         end
         if (data_mem_resp) dresp_cnt++;
      end
      n_checks++;
      if (dresp_cnt !== 1) begin
         n_fail++;
         $display("FAIL rw_both_resp: got %0d data resps, want 1", dresp_cnt);
      end
   endtask

   // Random traffic on both ports with random memory latency and stray
   // pmem_resp pulses while idle, checked against a transaction-level model.
   task automatic test_random(input int cycles);
      int owner;        // 0 none, 1 inst, 2 data
      bit data_next;
      bit take_data;
      int lat;
      int kind;
      bit i_pend, d_pend;
      logic i_rd, i_wr, d_rd, d_wr;
      logic [31:0] i_addr, i_wd, d_addr, d_wd;
      logic [3:0]  i_be, d_be;
      logic [31:0] c_addr, c_wd;
      logic        c_rd, c_wr;
      logic [3:0]  c_be;
      logic        exp_i, exp_d;
      do_reset();
      owner = 0; data_next = 1'b1; lat = 0;
      i_pend = 1'b0; d_pend = 1'b0;
      i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
      i_addr = 32'h0; i_wd = 32'h0; i_be = 4'h0;
      d_addr = 32'h0; d_wd = 32'h0; d_be = 4'h0;
      c_addr = 32'h0; c_wd = 32'h0; c_rd = 1'b0; c_wr = 1'b0; c_be = 4'h0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk); #1;
         inst_mem_address = i_addr; inst_mem_wdata = i_wd; inst_mem_byte_enable = i_be;
         inst_mem_read = i_pend & i_rd; inst_mem_write = i_pend & i_wr;
         data_mem_address = d_addr; data_mem_wdata = d_wd; data_mem_byte_enable = d_be;
         data_mem_read = d_pend & d_rd; data_mem_write = d_pend & d_wr;
         if (owner != 0) pmem_resp = (lat == 0);
         else pmem_resp = ($urandom_range(0, 3) == 0);
         pmem_rdata = $urandom;
         @(negedge clk);
         if (owner == 0) begin
            n_checks++;
            if ({pmem_read, pmem_write, inst_mem_resp, data_mem_resp,
                 inst_mem_rdata, data_mem_rdata} !== 68'h0) begin
               n_fail++;
               $display("FAIL rand_idle cycle %0d: got rd=%b wr=%b iresp=%b dresp=%b, want 0",
                        c, pmem_read, pmem_write, inst_mem_resp, data_mem_resp);
            end
            if (i_pend || d_pend) begin
               take_data = d_pend && (!i_pend || !RrEn || data_next);
               owner = take_data ? 2 : 1;
               c_addr = take_data ? d_addr : i_addr;
               c_wd   = take_data ? d_wd : i_wd;
               c_be   = take_data ? d_be : i_be;
               c_wr   = take_data ? d_wr : i_wr;
               c_rd   = (take_data ? d_rd : i_rd) & ~c_wr;
               data_next = !take_data;
               lat = $urandom_range(0, 3);
            end
         end else begin
            n_checks++;
            if ({pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata} !==
                {c_addr, c_rd, c_wr, c_be, c_wd}) begin
               n_fail++;
               $display("FAIL rand_bus cycle %0d: got addr=%h rd=%b wr=%b be=%h wd=%h, want %h %b %b %h %h",
                        c, pmem_address, pmem_read, pmem_write, pmem_byte_enable, pmem_wdata,
                        c_addr, c_rd, c_wr, c_be, c_wd);
            end
            exp_i = pmem_resp && (owner == 1);
            exp_d = pmem_resp && (owner == 2);
            n_checks++;
            if ({inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata} !==
                {exp_i, exp_d, exp_i ? pmem_rdata : 32'h0, exp_d ? pmem_rdata : 32'h0}) begin
               n_fail++;
               $display("FAIL rand_resp cycle %0d: got iresp=%b dresp=%b ird=%h drd=%h, want %b %b owner=%0d",
                        c, inst_mem_resp, data_mem_resp, inst_mem_rdata, data_mem_rdata,
                        exp_i, exp_d, owner);
            end
            if (pmem_resp) begin
               if (owner == 1) i_pend = 1'b0;
               else d_pend = 1'b0;
               owner = 0;
            end else begin
               lat--;
            end
         end
         if (!i_pend && $urandom_range(0, 2) != 0) begin
            kind = $urandom_range(0, 2);
            i_pend = 1'b1; i_rd = (kind != 1); i_wr = (kind != 0);
            i_addr = $urandom; i_wd = $urandom; i_be = 4'($urandom);
         end
         if (!d_pend && $urandom_range(0, 2) != 0) begin
            kind = $urandom_range(0, 2);
            d_pend = 1'b1; d_rd = (kind != 1); d_wr = (kind != 0);
            d_addr = $urandom; d_wd = $urandom; d_be = 4'($urandom);
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_inst_read();
      test_data_write();
      test_back_to_back();
      test_reset_mid();
      test_addr_hold();
      test_rw_both();
      test_random(3000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-003 inst_mem_address/read/write/byte_enable/wdata  in  32/1/1/4/32  CPU instruction port request.
REQ-004 inst_mem_rdata  out  32  read data to the instruction port; inst_mem_resp  out  1  completion pulse.
REQ-005 data_mem_address/read/write/byte_enable/wdata  in  32/1/1/4/32  CPU data port request.
REQ-006 data_mem_rdata  out  32  read data to the data port; data_mem_resp  out  1  completion pulse.
REQ-007 pmem_address/read/write/byte_enable/wdata  out  32/1/1/4/32  shared downstream memory request.
REQ-008 pmem_rdata  in  32  downstream read data; pmem_resp  in  1  downstream completion.

Function
REQ-009 The FSM SHALL have states IDLE, INST, DATA.
REQ-010 A port request SHALL be read|write; requesters hold all request signals stable until their resp.
REQ-011 IDLE with only a data request -> DATA; only an inst request -> INST; neither -> IDLE.
REQ-012 IDLE with both requests SHALL grant DATA (fixed priority) unless ARB_RR_EN is defined (see REQ-024).
REQ-013 On grant, address/read/write/byte_enable/wdata of the winning port SHALL be registered; pmem_* outputs SHALL be driven only from these registers.
REQ-014 pmem_read/pmem_write SHALL assert starting the cycle after grant and stay asserted until pmem_resp.
REQ-015 If a port asserts read and write together, the arbiter SHALL issue a write only.
REQ-016 In INST/DATA with pmem_resp=1, the owner's resp SHALL be 1 in that same cycle, its rdata SHALL equal pmem_rdata combinationally, and the FSM SHALL return to IDLE.
REQ-017 Non-owner resp SHALL be 0 at all times; each rdata SHALL be 0 when its resp is 0.
REQ-018 pmem_read/pmem_write SHALL be 0 in IDLE.
REQ-019 Minimum latency: request seen in IDLE at cycle t -> pmem request at t+1 -> port resp at t+1 at the earliest (same cycle as pmem_resp).
REQ-020 pmem_resp while in IDLE SHALL be ignored.
REQ-021 No new grant SHALL occur in the cycle pmem_resp is accepted; arbitration resumes in IDLE the next cycle.

Reset
REQ-022 rst=0 SHALL force state IDLE, clear all captured registers, set every output to 0, and clear the round-robin pointer to "data next".
REQ-023 Reset mid-transaction SHALL abandon the transaction without emitting a resp; a later pmem_resp arriving in IDLE is ignored per REQ-020.

Configuration
REQ-024 When ARB_RR_EN is defined, a last-served pointer SHALL select the port not served last when both request in IDLE; when undefined, data always wins and the pointer logic is absent.
REQ-025 Single-request behaviour SHALL be identical with and without ARB_RR_EN.

Verification
REQ-026 Inst read 0x0000_0060 alone, pmem_resp 2 cycles after pmem_read with rdata 0x0000_0013 -> pmem_address=0x60, inst_mem_resp for exactly 1 cycle with rdata 0x13, data_mem_resp=0.
REQ-027 Data write 0x100 with wdata 0xDEADBEEF and byte_enable 4'b0011 -> pmem_write=1 with exactly these values, data_mem_resp pulse; pmem_read=0 throughout.
REQ-028 Both request in the same cycle, three back-to-back rounds, ARB_RR_EN undefined -> order DATA,DATA,DATA while data stays asserted; with ARB_RR_EN defined -> DATA,INST,DATA.
REQ-029 Drop rst to 0 two cycles into a DATA read, release, drive a stale pmem_resp -> all outputs 0 during reset, no resp to either port, FSM in IDLE.
REQ-030 Inst request whose address changes while in INST -> pmem_address keeps the value captured at grant until pmem_resp.
REQ-031 Data port asserts read and write together for address 0x200 -> pmem_write=1, pmem_read=0, one data_mem_resp.
